// File: rtl/clock_ratio_detector_pkg.sv
// Shared types and constants for the clock ratio detector and its companions.
// The 6-bit ratio range and 64-cycle observation window match the clock divider.
package clk_pkg;

    localparam int RATIO_W        = 6;
    localparam int PERIOD_W       = 7;
    localparam int MATCH_W        = 4;
    localparam int TIMEOUT_CYCLES = 64;

    localparam logic [PERIOD_W-1:0] CNT_MAX    = PERIOD_W'(TIMEOUT_CYCLES);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        MEASURE,
        LOCKED
    } det_state_t;

    // A period can become a lock candidate only inside the 2..63 window.
    function automatic logic is_lockable(input logic [PERIOD_W-1:0] period);
        return (period >= MIN_PERIOD) && (period < CNT_MAX);
    endfunction

endpackage

// File: rtl/clock_ratio_detector_if.sv
// Control/status bundle between the control logic (master) and the detector (slave).
interface clock_ratio_detector_if;
    import clk_pkg::*;

    logic                detector_enable;
    logic                measured_clk;
    logic [RATIO_W-1:0]  detected_ratio;
    logic                ratio_valid;
    logic                ratio_change;
    logic                timeout_flag;

    modport master (
        output detector_enable, measured_clk,
        input  detected_ratio, ratio_valid, ratio_change, timeout_flag
    );

    modport slave (
        input  detector_enable, measured_clk,
        output detected_ratio, ratio_valid, ratio_change, timeout_flag
    );

endinterface

// File: rtl/clock_ratio_detector_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous clock-like signal, followed by a
// one-cycle rising-edge pulse in the reference domain.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic reference_clk,
    input  logic reset,
    input  logic i_async,
    output logic o_edge_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_delay;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= '0;
            r_delay <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_delay <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge_pulse = r_sync[SYNC_STAGES-1] & ~r_delay;

endmodule

// File: rtl/clock_ratio_detector.sv
// Measures the rising-edge spacing of measured_clk in reference_clk cycles and
// reports the integer ratio once LOCK_COUNT consecutive periods agree.
module clock_ratio_detector
    import clk_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                    reference_clk,
    input  logic                    reset,
    clock_ratio_detector_if.slave   det_if
);

    localparam logic [MATCH_W-1:0] LOCK_TARGET = MATCH_W'(LOCK_COUNT);

    det_state_t           r_state,          w_state_next;
    logic [PERIOD_W-1:0]  r_cnt,            w_cnt_next;
    logic [RATIO_W-1:0]   r_candidate,      w_candidate_next;
    logic [MATCH_W-1:0]   r_match,          w_match_next;
    logic [RATIO_W-1:0]   r_detected_ratio, w_detected_ratio_next;
    logic                 r_ratio_valid,    w_ratio_valid_next;
    logic                 r_ratio_change,   w_ratio_change_next;
    logic                 r_timeout_flag,   w_timeout_flag_next;
    logic                 r_locked_once,    w_locked_once_next;

    logic                 w_edge;
    logic                 w_period_ok;
    logic [RATIO_W-1:0]   w_period_ratio;
    logic [MATCH_W-1:0]   w_match_sum;
    logic [PERIOD_W-1:0]  w_cnt_step;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .reference_clk (reference_clk),
        .reset         (reset),
        .i_async       (det_if.measured_clk),
        .o_edge_pulse  (w_edge)
    );

    // The captured period is simply the counter value seen on the edge cycle.
    assign w_period_ok    = is_lockable(r_cnt);
    assign w_period_ratio = r_cnt[RATIO_W-1:0];
    assign w_match_sum    = (w_period_ratio == r_candidate) ? r_match + MATCH_W'(1) : MATCH_W'(1);
    assign w_cnt_step     = w_edge              ? PERIOD_W'(1) :
                            (r_cnt == CNT_MAX)  ? r_cnt        : r_cnt + PERIOD_W'(1);

    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_cnt            <= '0;
            r_candidate      <= '0;
            r_match          <= '0;
            r_detected_ratio <= '0;
            r_ratio_valid    <= 1'b0;
            r_ratio_change   <= 1'b0;
            r_timeout_flag   <= 1'b0;
            r_locked_once    <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_cnt            <= w_cnt_next;
            r_candidate      <= w_candidate_next;
            r_match          <= w_match_next;
            r_detected_ratio <= w_detected_ratio_next;
            r_ratio_valid    <= w_ratio_valid_next;
            r_ratio_change   <= w_ratio_change_next;
            r_timeout_flag   <= w_timeout_flag_next;
            r_locked_once    <= w_locked_once_next;
        end
    end

    // NOTE: every signal driven here is given a default first so no path through
    // the case statements leaves it unassigned and infers a latch.
    always_comb begin
        w_state_next          = r_state;
        w_cnt_next            = r_cnt;
        w_candidate_next      = r_candidate;
        w_match_next          = r_match;
        w_detected_ratio_next = r_detected_ratio;
        w_ratio_valid_next    = r_ratio_valid;
        w_ratio_change_next   = 1'b0;
        w_timeout_flag_next   = r_timeout_flag;
        w_locked_once_next    = r_locked_once;

        if (!det_if.detector_enable) begin
            w_state_next        = IDLE;
            w_cnt_next          = '0;
            w_candidate_next    = '0;
            w_match_next        = '0;
            w_ratio_valid_next  = 1'b0;
            w_timeout_flag_next = 1'b0;
        end else if (r_state == IDLE) begin
            w_state_next = ACQUIRE;
        end else begin
            w_cnt_next = w_cnt_step;

            // An edge landing on a saturated counter is a period of 64, not a timeout.
            if (w_edge) begin
                w_timeout_flag_next = 1'b0;
            end else if (r_cnt == CNT_MAX) begin
                w_timeout_flag_next = 1'b1;
                w_ratio_valid_next  = 1'b0;
                w_candidate_next    = '0;
                w_match_next        = '0;
                w_state_next        = ACQUIRE;
            end

            if (w_edge) begin
                case (r_state)
                    ACQUIRE: w_state_next = MEASURE;
                    MEASURE: begin
                        if (!w_period_ok) begin
                            w_candidate_next = '0;
                            w_match_next     = '0;
                        end else begin
                            w_candidate_next = w_period_ratio;
                            w_match_next     = w_match_sum;
                            if (w_match_sum == LOCK_TARGET) begin
                                w_state_next          = LOCKED;
                                w_detected_ratio_next = w_period_ratio;
                                w_ratio_valid_next    = 1'b1;
                                w_ratio_change_next   = (w_period_ratio != r_detected_ratio) || !r_locked_once;
                                w_locked_once_next    = 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (!(w_period_ok && (w_period_ratio == r_detected_ratio))) begin
                            w_ratio_valid_next = 1'b0;
                            w_candidate_next   = w_period_ok ? w_period_ratio : '0;
                            w_match_next       = w_period_ok ? MATCH_W'(1) : '0;
                            w_state_next       = MEASURE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign det_if.detected_ratio = r_detected_ratio;
    assign det_if.ratio_valid    = r_ratio_valid;
    assign det_if.ratio_change   = r_ratio_change;
    assign det_if.timeout_flag   = r_timeout_flag;

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Directed bench for clock_ratio_detector: a table of ratio phases plus
// hand-timed sequences for timeout, jitter, enable and reset corner cases.
module tb_clock_ratio_detector;
    import clk_pkg::*;

    logic reference_clk = 1'b0;
    logic reset         = 1'b0;

    clock_ratio_detector_if det_if ();

    clock_ratio_detector #(
        .SYNC_STAGES (2),
        .LOCK_COUNT  (4)
    ) dut (
        .reference_clk (reference_clk),
        .reset         (reset),
        .det_if        (det_if.slave)
    );

    always #5 reference_clk = ~reference_clk;

    typedef struct {
        int high;
        int low;
        int periods;
        int exp_valid;
        int exp_ratio;
        int exp_changes;
        int exp_falls;
        int exp_timeout;
    } vec_t;

    vec_t vecs [8];

    int n_checks = 0;
    int n_errors = 0;
    int chg_cnt  = 0;
    int fall_cnt = 0;
    logic prev_valid = 1'b0;

    // Event counters sampled mid-cycle, well away from both clock edges.
    always begin
        @(posedge reference_clk);
        #2;
        if (reset) begin
            if (det_if.ratio_change) chg_cnt++;
            if (prev_valid && !det_if.ratio_valid) fall_cnt++;
        end
        prev_valid = det_if.ratio_valid;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            det_if.measured_clk = 1'b1;
            repeat (h) @(negedge reference_clk);
            det_if.measured_clk = 1'b0;
            repeat (l) @(negedge reference_clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int c0;
        int f0;

        //           high low per valid ratio chg fall tmo
        vecs[0] = '{3,  3,  8,  1,  6,  1, 0, 0};
        vecs[1] = '{4,  3,  6,  1,  7,  1, 1, 0};
        vecs[2] = '{4,  3,  100,1,  7,  0, 0, 0};
        vecs[3] = '{5,  5,  6,  1,  10, 1, 1, 0};
        vecs[4] = '{1,  1,  8,  1,  2,  1, 1, 0};
        vecs[5] = '{32, 31, 6,  1,  63, 1, 1, 0};
        vecs[6] = '{32, 32, 6,  0,  63, 0, 1, 0};
        vecs[7] = '{3,  3,  8,  1,  6,  1, 0, 0};

        det_if.detector_enable = 1'b0;
        det_if.measured_clk    = 1'b0;
        #1;
        check("reset_ratio",   32'(det_if.detected_ratio), 0);
        check("reset_valid",   32'(det_if.ratio_valid),    0);
        check("reset_change",  32'(det_if.ratio_change),   0);
        check("reset_timeout", 32'(det_if.timeout_flag),   0);
        repeat (3) @(negedge reference_clk);
        reset = 1'b1;
        @(negedge reference_clk);
        det_if.detector_enable = 1'b1;

        for (int i = 0; i < 8; i++) begin
            c0 = chg_cnt;
            f0 = fall_cnt;
            drive(vecs[i].high, vecs[i].low, vecs[i].periods);
            check($sformatf("row%0d_valid", i),   32'(det_if.ratio_valid),    vecs[i].exp_valid);
            check($sformatf("row%0d_ratio", i),   32'(det_if.detected_ratio), vecs[i].exp_ratio);
            check($sformatf("row%0d_changes", i), chg_cnt - c0,               vecs[i].exp_changes);
            check($sformatf("row%0d_falls", i),   fall_cnt - f0,              vecs[i].exp_falls);
            check($sformatf("row%0d_timeout", i), 32'(det_if.timeout_flag),   vecs[i].exp_timeout);
        end

        // Stopped clock while locked at 6: flag rises exactly 64 cycles after the last edge.
        det_if.measured_clk = 1'b1;
        repeat (3) @(negedge reference_clk);
        det_if.measured_clk = 1'b0;
        repeat (63) @(negedge reference_clk);
        check("timeout_before_flag",  32'(det_if.timeout_flag), 0);
        check("timeout_before_valid", 32'(det_if.ratio_valid),  1);
        @(negedge reference_clk);
        check("timeout_flag_set",     32'(det_if.timeout_flag), 1);
        check("timeout_valid_drop",   32'(det_if.ratio_valid),  0);

        // Resume at ratio 4: first edge clears the flag, then lock at 4.
        c0 = chg_cnt;
        det_if.measured_clk = 1'b1;
        repeat (2) @(negedge reference_clk);
        check("resume_flag_held",    32'(det_if.timeout_flag), 1);
        det_if.measured_clk = 1'b0;
        @(negedge reference_clk);
        check("resume_flag_cleared", 32'(det_if.timeout_flag), 0);
        @(negedge reference_clk);
        drive(2, 2, 5);
        check("resume_valid",   32'(det_if.ratio_valid),    1);
        check("resume_ratio",   32'(det_if.detected_ratio), 4);
        check("resume_changes", chg_cnt - c0,               1);

        // Alternating 5/6 jitter never locks; detected ratio holds.
        c0 = chg_cnt;
        f0 = fall_cnt;
        for (int i = 0; i < 10; i++) begin
            drive(2, 3, 1);
            drive(3, 3, 1);
        end
        check("jitter_valid",   32'(det_if.ratio_valid),    0);
        check("jitter_ratio",   32'(det_if.detected_ratio), 4);
        check("jitter_changes", chg_cnt - c0,               0);
        check("jitter_falls",   fall_cnt - f0,              1);

        c0 = chg_cnt;
        drive(3, 3, 8);
        check("relock6_valid",   32'(det_if.ratio_valid),    1);
        check("relock6_ratio",   32'(det_if.detected_ratio), 6);
        check("relock6_changes", chg_cnt - c0,               1);

        // Disable while locked, then re-enable at the same ratio.
        det_if.detector_enable = 1'b0;
        @(negedge reference_clk);
        check("disable_valid",   32'(det_if.ratio_valid),    0);
        check("disable_ratio",   32'(det_if.detected_ratio), 6);
        check("disable_timeout", 32'(det_if.timeout_flag),   0);
        repeat (8) @(negedge reference_clk);
        c0 = chg_cnt;
        det_if.detector_enable = 1'b1;
        drive(3, 3, 4);
        det_if.measured_clk = 1'b1;
        repeat (2) @(negedge reference_clk);
        check("reenable_lock_early", 32'(det_if.ratio_valid), 0);
        @(negedge reference_clk);
        check("reenable_lock_exact", 32'(det_if.ratio_valid), 1);
        det_if.measured_clk = 1'b0;
        repeat (3) @(negedge reference_clk);
        drive(3, 3, 3);
        check("reenable_ratio",   32'(det_if.detected_ratio), 6);
        check("reenable_changes", chg_cnt - c0,               0);
        check("reenable_valid",   32'(det_if.ratio_valid),    1);

        // Asynchronous reset mid-lock.
        #2;
        reset = 1'b0;
        #1;
        check("midreset_ratio",   32'(det_if.detected_ratio), 0);
        check("midreset_valid",   32'(det_if.ratio_valid),    0);
        check("midreset_change",  32'(det_if.ratio_change),   0);
        check("midreset_timeout", 32'(det_if.timeout_flag),   0);
        @(negedge reference_clk);
        reset = 1'b1;
        @(negedge reference_clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
